sample_feeder: RTL and testbench
================================

SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 8, signed width of x1, x2, t.
- DEPTH, 16, number of sample slots.
- ADDR_W, 4, log2(DEPTH).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wrEn  in  1  sample write strobe.
- wrAddr  in  ADDR_W  write slot.
- wrX1  in  DATA_W  write data, x1.
- wrX2  in  DATA_W  write data, x2.
- wrT  in  DATA_W  write data, target.
- numSamples  in  ADDR_W+1  active sample count, captured at reset/rewind.
- rewind  in  1  restart epoch; driven by the neuron controller's counterReset.
- requestFlag  in  1  level request from the neuron controller.
- dataReady  out  1  one-cycle pulse: sample outputs valid.
- x1  out  DATA_W  sample input 1.
- x2  out  DATA_W  sample input 2.
- t  out  DATA_W  sample target.
- flagEOF  out  1  delivered sample is the last one of the epoch.
- sampleIdx  out  ADDR_W  index of the next sample to fetch.
- epochCnt  out  8  completed epochs, saturating at 255.
- busy  out  1  FSM not in IDLE.

Function
REQ-003 FSM states SHALL be IDLE, READ, VALID, WAITLOW, with these transitions:
- IDLE -> READ when requestFlag=1.
- READ -> VALID unconditionally.
- VALID -> WAITLOW unconditionally.
- WAITLOW -> IDLE when requestFlag=0.
REQ-004 In READ, sampleIdx SHALL address sample_ram; the synchronous read data SHALL be registered into x1/x2/t on entry to VALID.
REQ-005 dataReady SHALL be 1 only in VALID, so a request sampled high in cycle N yields dataReady in cycle N+2.
REQ-006 x1, x2, t and flagEOF SHALL hold their values from the VALID load until the next VALID load, rewind or reset.
REQ-007 flagEOF SHALL be loaded in VALID as (sampleIdx == effN-1).
REQ-008 effN SHALL equal the captured numSamples, or DEPTH when the captured value is 0 or greater than DEPTH.
REQ-009 In VALID, sampleIdx SHALL increment, or wrap to 0 when it equals effN-1.
REQ-010 On that wrap, epochCnt SHALL increment, saturating at 255.
REQ-011 A request held high through WAITLOW SHALL NOT start a second fetch; requestFlag must be seen low first.
REQ-012 rewind SHALL, in every state, take effect on the next edge:
- sampleIdx <= 0, flagEOF <= 0, dataReady <= 0.
- FSM <= IDLE; an in-flight fetch is aborted.
- numSamples recaptured; epochCnt unchanged.
REQ-013 If rewind and requestFlag are both high, rewind SHALL win; the still-high request is served from index 0 starting the following cycle.
REQ-014 When wrEn writes the slot being read in the same cycle, the read SHALL return the old contents (read-first).
REQ-015 Writes SHALL be accepted in every state and SHALL NOT disturb the FSM.

Reset
REQ-016 On rst=1 at a clock edge:
- FSM = IDLE.
- dataReady, flagEOF, busy = 0.
- x1, x2, t, sampleIdx, epochCnt = 0.
- numSamples captured.
- sample_ram contents are not cleared.
REQ-017 rst SHALL take priority over rewind, requestFlag and wrEn.

Structure
REQ-018 A shared package SHALL hold DATA_W, DEPTH, ADDR_W defaults and the FSM state encoding, for reuse by the neuron datapath.
REQ-019 Storage SHALL be one sub-module, sample_ram: DEPTH x (3*DATA_W), one write port, one synchronous read-first read port.
REQ-020 Target size SHALL be 120-400 RTL lines, with no combinational path from requestFlag to dataReady.

Verification
REQ-021 Fetch latency: write slots 0..2 = (3,-2,1), (-5,4,-1), (7,7,1); numSamples=3; rewind; raise requestFlag at cycle 10 -> dataReady pulses at cycle 12 only; x1=3, x2=-2, t=1; flagEOF=0; sampleIdx=1.
REQ-022 EOF and wrap: three handshakes -> third delivers (7,7,1) with flagEOF=1; sampleIdx=0; epochCnt=1; the fourth delivers slot 0 again.
REQ-023 Request held high: keep requestFlag=1 for 6 cycles -> exactly one dataReady pulse.
REQ-024 Rewind mid-fetch: assert rewind in READ -> no dataReady that cycle or the next; sampleIdx=0; the following request returns slot 0.
REQ-025 Bounds: numSamples=0 -> flagEOF first set on index 15; numSamples=1 -> flagEOF=1 on every delivery and epochCnt increments per delivery, saturating at 255.
REQ-026 Write collision: write (9,9,9) to the slot under READ -> old data delivered; a re-fetch after rewind returns (9,9,9).

Source files
------------

// File: rtl/sample_feeder_pkg.sv
// Shared sizing defaults and fetch FSM encoding for the sample feeder and
// the neuron datapath that consumes its samples.
package sample_feeder_pkg;

  localparam int SF_DATA_W = 8;
  localparam int SF_DEPTH  = 16;
  localparam int SF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    VALID   = 2'd2,
    WAITLOW = 2'd3
  } state_t;

endpackage

// File: rtl/sample_feeder_ram.sv
// Sample storage: DEPTH words of {x1, x2, t}, one write port and one
// synchronous read-first read port whose output register holds until re_i.
module sample_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [3*DATA_W-1:0]   wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [3*DATA_W-1:0]   rdata_o
);

  logic [3*DATA_W-1:0] mem [DEPTH];
  logic [3*DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset branch on purpose; clearing it would turn
  // it into a flop bank and training data must survive a reset anyway.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // NOTE: non-blocking assignment means a same-edge write to raddr_i is not
  // yet visible here, which gives the required read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_feeder.sv
// Hands one training sample per request handshake to the neuron controller,
// walking the active sample window and counting completed epochs.
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int DATA_W = SF_DATA_W,
  parameter int DEPTH  = SF_DEPTH,
  parameter int ADDR_W = SF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic signed [DATA_W-1:0] wrX1,
  input  logic signed [DATA_W-1:0] wrX2,
  input  logic signed [DATA_W-1:0] wrT,
  input  logic [ADDR_W:0]          numSamples,
  input  logic                     rewind,
  input  logic                     requestFlag,
  output logic                     dataReady,
  output logic signed [DATA_W-1:0] x1,
  output logic signed [DATA_W-1:0] x2,
  output logic signed [DATA_W-1:0] t,
  output logic                     flagEOF,
  output logic [ADDR_W-1:0]        sampleIdx,
  output logic [7:0]               epochCnt,
  output logic                     busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     num_q;
  logic [ADDR_W:0]     eff_n;
  logic [ADDR_W-1:0]   idx_q;
  logic                flag_q;
  logic [7:0]          epoch_q;
  logic                fetch_go;
  logic                at_last;
  logic [3*DATA_W-1:0] rdata;

  // A zero or oversized count means "use every slot".
  assign eff_n    = (num_q == '0 || num_q > DEPTH_L) ? DEPTH_L : num_q;
  assign at_last  = ({1'b0, idx_q} == eff_n - (ADDR_W+1)'(1));
  assign fetch_go = (state_q == READ) && !rewind;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave state_d unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (requestFlag) state_d = READ;
      READ:    state_d = VALID;
      VALID:   state_d = WAITLOW;
      WAITLOW: if (!requestFlag) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rewind) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= numSamples;
      idx_q   <= '0;
      flag_q  <= 1'b0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      if (rewind) begin
        num_q  <= numSamples;
        idx_q  <= '0;
        flag_q <= 1'b0;
      end else if (state_q == READ) begin
        // Sample bookkeeping lands together with the data entering VALID.
        flag_q <= at_last;
        idx_q  <= at_last ? '0 : idx_q + ADDR_W'(1);
        if (at_last && epoch_q != 8'hFF) epoch_q <= epoch_q + 8'd1;
      end
    end
  end

  sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wrEn && !rst),
    .waddr_i (wrAddr),
    .wdata_i ({wrX1, wrX2, wrT}),
    .re_i    (fetch_go),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  assign x1        = rdata[3*DATA_W-1:2*DATA_W];
  assign x2        = rdata[2*DATA_W-1:DATA_W];
  assign t         = rdata[DATA_W-1:0];
  assign dataReady = (state_q == VALID);
  assign busy      = (state_q != IDLE);
  assign flagEOF   = flag_q;
  assign sampleIdx = idx_q;
  assign epochCnt  = epoch_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Self-checking bench for sample_feeder: directed scenarios plus random
// writes, fetches and rewinds checked against a sample-level reference model.
module tb_sample_feeder;

  logic       clk = 1'b0;
  logic       rst, wrEn, rewind, requestFlag;
  logic [3:0] wrAddr;
  logic [7:0] wrX1, wrX2, wrT;
  logic [4:0] numSamples;
  logic       dataReady, flagEOF, busy;
  logic [7:0] x1, x2, t, epochCnt;
  logic [3:0] sampleIdx;

  int checks = 0;
  int errors = 0;

  // Reference model: slot contents, next index, window size, epoch count.
  logic [23:0] m_mem [16];
  int          m_idx, m_eff, m_epoch;

  always #5 clk = ~clk;

  sample_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .wrX1        (wrX1),
    .wrX2        (wrX2),
    .wrT         (wrT),
    .numSamples  (numSamples),
    .rewind      (rewind),
    .requestFlag (requestFlag),
    .dataReady   (dataReady),
    .x1          (x1),
    .x2          (x2),
    .t           (t),
    .flagEOF     (flagEOF),
    .sampleIdx   (sampleIdx),
    .epochCnt    (epochCnt),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_of(input int n);
    return (n == 0 || n > 16) ? 16 : n;
  endfunction

  task automatic write_slot(input logic [3:0] a, input logic [7:0] v1, v2, vt);
    @(negedge clk);
    wrEn = 1'b1; wrAddr = a; wrX1 = v1; wrX2 = v2; wrT = vt;
    @(negedge clk);
    wrEn = 1'b0;
    m_mem[a] = {v1, v2, vt};
  endtask

  task automatic do_rewind(input logic [4:0] n);
    @(negedge clk);
    rewind = 1'b1; numSamples = n;
    @(negedge clk);
    rewind = 1'b0;
    m_idx = 0;
    m_eff = eff_of(int'(n));
    check("rew_idx", sampleIdx, 0);
    check("rew_eof", flagEOF, 0);
    check("rew_busy", busy, 0);
  endtask

  // One full handshake; optionally writes a slot during the READ cycle.
  task automatic fetch(input bit do_wr, input logic [3:0] wa, input logic [7:0] v1, v2, vt);
    logic [23:0] e;
    logic        ef;
    @(negedge clk);
    requestFlag = 1'b1;
    @(posedge clk); #1;
    check("lat_read_dr", dataReady, 0);
    check("lat_read_busy", busy, 1);
    @(negedge clk);
    if (do_wr) begin
      wrEn = 1'b1; wrAddr = wa; wrX1 = v1; wrX2 = v2; wrT = vt;
    end
    @(posedge clk); #1;
    e  = m_mem[m_idx];
    ef = (m_idx == m_eff - 1);
    m_idx = ef ? 0 : m_idx + 1;
    if (ef && m_epoch < 255) m_epoch++;
    if (do_wr) m_mem[wa] = {v1, v2, vt};
    check("valid_dr", dataReady, 1);
    check("valid_x1", x1, e[23:16]);
    check("valid_x2", x2, e[15:8]);
    check("valid_t", t, e[7:0]);
    check("valid_eof", flagEOF, ef);
    check("valid_idx", sampleIdx, m_idx);
    check("valid_epoch", epochCnt, m_epoch);
    @(negedge clk);
    wrEn = 1'b0; requestFlag = 1'b0;
    @(posedge clk); #1;
    check("waitlow_dr", dataReady, 0);
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int pulses;
    logic [23:0] e;
    rst = 1'b1; wrEn = 1'b0; rewind = 1'b0; requestFlag = 1'b0;
    wrAddr = '0; wrX1 = '0; wrX2 = '0; wrT = '0; numSamples = 5'd3;
    m_idx = 0; m_eff = 3; m_epoch = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_dr", dataReady, 0);
    check("rst_eof", flagEOF, 0);
    check("rst_busy", busy, 0);
    check("rst_x", {x1, x2, t}, 0);
    check("rst_idx", sampleIdx, 0);
    check("rst_epoch", epochCnt, 0);

    // Zero every slot so the model matches regardless of power-up contents.
    for (int i = 0; i < 16; i++) write_slot(4'(i), 8'd0, 8'd0, 8'd0);

    // Fetch latency and first delivery.
    write_slot(4'd0, 8'd3, -8'sd2, 8'd1);
    write_slot(4'd1, -8'sd5, 8'd4, -8'sd1);
    write_slot(4'd2, 8'd7, 8'd7, 8'd1);
    do_rewind(5'd3);
    fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);

    // EOF on slot 2, wrap, then slot 0 again.
    fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
    fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
    fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);

    // Request held high for six cycles yields one pulse.
    @(negedge clk);
    requestFlag = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (dataReady) pulses++;
    end
    check("hold_pulses", pulses, 1);
    e = m_mem[m_idx];
    m_idx = (m_idx == m_eff - 1) ? 0 : m_idx + 1;
    check("hold_x1", x1, e[23:16]);
    check("hold_idx", sampleIdx, m_idx);
    @(negedge clk);
    requestFlag = 1'b0;
    @(posedge clk); #1;
    check("hold_release_busy", busy, 0);

    // Rewind while in READ aborts the fetch.
    @(negedge clk);
    requestFlag = 1'b1;
    @(posedge clk); #1;
    check("abort_in_read", busy, 1);
    @(negedge clk);
    rewind = 1'b1; requestFlag = 1'b0;
    @(posedge clk); #1;
    check("abort_dr0", dataReady, 0);
    check("abort_idx", sampleIdx, 0);
    @(negedge clk);
    rewind = 1'b0;
    @(posedge clk); #1;
    check("abort_dr1", dataReady, 0);
    m_idx = 0;
    fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);

    // Rewind and request together: rewind wins, request served after.
    @(negedge clk);
    rewind = 1'b1; requestFlag = 1'b1;
    @(posedge clk); #1;
    check("rw_req_idle", busy, 0);
    @(negedge clk);
    rewind = 1'b0;
    m_idx = 0;
    @(posedge clk); #1;
    check("rw_req_read", busy, 1);
    @(posedge clk); #1;
    check("rw_req_dr", dataReady, 1);
    check("rw_req_x1", x1, m_mem[0][23:16]);
    m_idx = 1;
    @(negedge clk);
    requestFlag = 1'b0;
    repeat (2) @(posedge clk);

    // Read-first collision, then re-fetch after rewind sees the new data.
    do_rewind(5'd3);
    fetch(1'b1, 4'd0, 8'd9, 8'd9, 8'd9);
    do_rewind(5'd3);
    fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
    check("collide_new", {x1, x2, t}, 24'h090909);

    // Full-depth window: EOF only on index 15.
    do_rewind(5'd0);
    for (int i = 0; i < 16; i++) fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);

    // Random writes, fetches (some colliding) and rewinds.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: write_slot(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        1: fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
        2: fetch(1'b1, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        default: do_rewind(5'($urandom_range(0, 31)));
      endcase
    end

    // Single-sample window: EOF every delivery, epoch saturates at 255.
    do_rewind(5'd1);
    for (int i = 0; i < 260; i++) fetch(1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
    check("epoch_sat", epochCnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
